fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one fifo_flops instance among n_req producers.
- Selects one requester per cycle, with bounded burst ownership, and registers its word onto the FIFO push/Din side.
- Tracks FIFO occupancy with an internal credit counter so it never pushes into a full FIFO.
- Sits between producer agents and fifo_flops; the FIFO pop side stays with the consumer, and only its pop strobe is mirrored here.

---
 rtl/fifo_arb_pkg.sv | 38 +++
 rtl/fifo_wr_arbiter_rr.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int MAX_REQ = 8;
    localparam int PTR_W   = $clog2(MAX_REQ);

    localparam int DEPTH = 8;
    localparam int N_REQ = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(N_REQ);

    // First set, non-excluded request scanning ptr, ptr+1, ... modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr,
        input logic [MAX_REQ-1:0] exclude,
        input int                 n
    );
        logic [MAX_REQ-1:0] pick;
        logic [PTR_W-1:0]   idx;
        int                 pos;
        pick = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            pos = (int'(ptr) + k) % n;
            idx = PTR_W'(pos);
            if (k < n && pick == '0 && req[idx] && !exclude[idx]) begin
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Pure round-robin picker: returns the index of the winner starting from ptr.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int n_req = 4
) (
    input  logic [n_req-1:0]         req,
    input  logic [$clog2(n_req)-1:0] ptr,
    input  logic [n_req-1:0]         exclude,
    output logic [$clog2(n_req)-1:0] idx,
    output logic                     any
);
    localparam int idx_w = $clog2(n_req);

    logic [MAX_REQ-1:0] req_w;
    logic [MAX_REQ-1:0] excl_w;
    logic [MAX_REQ-1:0] pick_w;
    logic [PTR_W-1:0]   ptr_w;

    always_comb begin
        req_w  = '0;
        excl_w = '0;
        ptr_w  = '0;
        req_w[n_req-1:0]  = req;
        excl_w[n_req-1:0] = exclude;
        ptr_w[idx_w-1:0]  = ptr;
        pick_w = rr_pick(req_w, ptr_w, excl_w, n_req);
        idx = '0;
        for (int i = 0; i < n_req; i++) begin
            if (pick_w[i]) idx = idx_w'(i);
        end
        any = |pick_w;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with bounded bursts feeding one fifo_flops push port,
// using a credit counter so the FIFO is never pushed while full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int width     = 16,
    parameter int depth     = 8,
    parameter int n_req     = 4,
    parameter int max_burst = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [n_req-1:0]             req,
    input  logic [n_req*width-1:0]       din,
    output logic [n_req-1:0]             gnt,
    output logic                         fifo_push,
    output logic [width-1:0]             fifo_din,
    input  logic                         fifo_pop,
    input  logic                         fifo_full,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         ovf_err,
    output state_t                       dbg_state,
    output logic [$clog2(n_req)-1:0]     dbg_ptr
);
    localparam int cnt_w = $clog2(depth + 1);
    localparam int idx_w = $clog2(n_req);

    // Handshake: req[i] is valid and holds din lane i stable; gnt[i] is the
    // ready, and the word is consumed on the clock edge where req[i] & gnt[i].

    state_t           state, state_nxt;
    logic [idx_w-1:0] ptr, ptr_nxt;
    logic [idx_w-1:0] owner, owner_nxt, owner_inc;
    logic [idx_w-1:0] arb_ptr, arb_idx, win;
    logic [n_req-1:0] arb_excl;
    logic             arb_any;
    logic [3:0]       burst_cnt, burst_nxt;
    logic             can_grant, grant, pop_ok;

    assign owner_inc = (owner == idx_w'(n_req - 1)) ? '0 : owner + idx_w'(1);
    assign can_grant = rst && (count < cnt_w'(depth));
    assign pop_ok    = fifo_pop && (count != '0);

    always_comb begin
        arb_ptr  = ptr;
        arb_excl = '0;
        if (state == OWN) begin
            arb_ptr         = owner_inc;
            arb_excl[owner] = 1'b1;
        end
    end

    rr_arbiter #(.n_req(n_req)) u_rr (
        .req     (req),
        .ptr     (arb_ptr),
        .exclude (arb_excl),
        .idx     (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        grant     = 1'b0;
        win       = owner;
        case (state)
            IDLE: begin
                if (can_grant && arb_any) begin
                    grant     = 1'b1;
                    win       = arb_idx;
                    state_nxt = OWN;
                    owner_nxt = arb_idx;
                    burst_nxt = 4'd1;
                end
            end
            OWN: begin
                if (!can_grant) begin
                    state_nxt = OWN;
                end else if (req[owner] && burst_cnt < 4'(max_burst)) begin
                    grant     = 1'b1;
                    burst_nxt = burst_cnt + 4'd1;
                end else begin
                    // Burst over: hand off past the owner; it may keep the
                    // bus only when nobody else is asking.
                    ptr_nxt = owner_inc;
                    if (arb_any) begin
                        grant     = 1'b1;
                        win       = arb_idx;
                        owner_nxt = arb_idx;
                        burst_nxt = 4'd1;
                    end else if (req[owner]) begin
                        grant     = 1'b1;
                        burst_nxt = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (grant) gnt[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_push <= 1'b0;
            fifo_din  <= '0;
            count     <= '0;
            ovf_err   <= 1'b0;
        end else begin
            fifo_push <= grant;
            if (grant) fifo_din <= din[win*width +: width];
            case ({grant, pop_ok})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
            if ((fifo_push && fifo_full) || (fifo_pop && count == '0)) ovf_err <= 1'b1;
        end
    end

    assign dbg_state = state;
    assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural fifo_flops model on the push side.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int N  = 4;
    localparam int MB = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req;
    logic [N*W-1:0]   din;
    logic [N-1:0]     gnt;
    logic             fifo_push;
    logic [W-1:0]     fifo_din;
    logic             fifo_pop;
    logic             fifo_full;
    logic [CNT_W-1:0] count;
    logic             ovf_err;
    state_t           dbg_state;
    logic [IDX_W-1:0] dbg_ptr;

    logic             force_full;
    int               fifo_cnt;
    logic [W-1:0]     fifo_q[$];
    logic [W-1:0]     exp_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               order[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.width(W), .depth(D), .n_req(N), .max_burst(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .fifo_push (fifo_push),
        .fifo_din  (fifo_din),
        .fifo_pop  (fifo_pop),
        .fifo_full (fifo_full),
        .count     (count),
        .ovf_err   (ovf_err),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // fifo_flops stand-in
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_q.delete();
            fifo_cnt <= 0;
        end else begin
            if (fifo_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (fifo_push) fifo_q.push_back(fifo_din);
            fifo_cnt <= fifo_q.size();
        end
    end

    assign fifo_full = force_full || (fifo_cnt == D);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] w);
        din[i*W +: W] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        din = '0;
        fifo_pop = 1'b0;
        force_full = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        req = '0;
        din = '0;
        fifo_pop = 1'b0;
        force_full = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_gnt",   32'(gnt), 0);
        check_eq("rst_push",  32'(fifo_push), 0);
        check_eq("rst_din",   32'(fifo_din), 0);
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_ovf",   32'(ovf_err), 0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        check_eq("rst_ptr",   32'(dbg_ptr), 0);

        // single requester, three words
        do_reset();
        @(negedge clk); req = 4'b0100; set_lane(2, 16'hA001); #1;
        check_eq("t1_gnt0", 32'(gnt), 4);
        @(negedge clk); set_lane(2, 16'hA002); #1;
        check_eq("t1_gnt1", 32'(gnt), 4);
        check_eq("t1_push1", 32'(fifo_push), 1);
        check_eq("t1_din1", 32'(fifo_din), 'hA001);
        @(negedge clk); set_lane(2, 16'hA003); #1;
        check_eq("t1_gnt2", 32'(gnt), 4);
        check_eq("t1_push2", 32'(fifo_push), 1);
        check_eq("t1_din2", 32'(fifo_din), 'hA002);
        @(negedge clk); req = '0; #1;
        check_eq("t1_gnt3", 32'(gnt), 0);
        check_eq("t1_push3", 32'(fifo_push), 1);
        check_eq("t1_din3", 32'(fifo_din), 'hA003);
        check_eq("t1_count3", 32'(count), 3);
        @(negedge clk); #1;
        check_eq("t1_push4", 32'(fifo_push), 0);
        check_eq("t1_count4", 32'(count), 3);
        check_eq("t1_idle", 32'(dbg_state), 32'(IDLE));
        exp_q = '{16'hA001, 16'hA002, 16'hA003};
        check_eq("t1_fifo_len", fifo_q.size(), 3);
        for (int i = 0; i < 3 && i < fifo_q.size(); i++)
            check_eq("t1_fifo_order", 32'(fifo_q[i]), 32'(exp_q[i]));

        // all requesters, bursts of two, pops keep count low
        do_reset();
        for (int i = 0; i < N; i++) set_lane(i, 16'(16'hB000 + i));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); req = 4'hF; fifo_pop = (k >= 2); #1;
            check_eq("t2_order", 32'(gnt), 32'(1) << order[k]);
            check_eq("t2_onehot", 32'($onehot0(gnt)), 1);
        end
        @(negedge clk); req = '0; fifo_pop = 1'b0; #1;
        check_eq("t2_count", 32'(count), 2);

        // fill to depth with no pops
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); req = 4'hF; #1;
            check_eq("t3_fill_gnt", 32'(gnt), 32'(1) << (k / 2));
            check_eq("t3_no_push_full", 32'(fifo_push && fifo_full), 0);
        end
        @(negedge clk); #1;
        check_eq("t3_gnt_full", 32'(gnt), 0);
        check_eq("t3_count8", 32'(count), 8);
        check_eq("t3_no_push_full", 32'(fifo_push && fifo_full), 0);
        @(negedge clk); fifo_pop = 1'b1; #1;
        check_eq("t3_gnt_pop", 32'(gnt), 0);
        check_eq("t3_fifo_full", 32'(fifo_full), 1);
        check_eq("t3_push_idle", 32'(fifo_push), 0);
        @(negedge clk); fifo_pop = 1'b0; #1;
        check_eq("t3_count7", 32'(count), 7);
        check_eq("t3_regrant", 32'(gnt), 1);
        @(negedge clk); #1;
        check_eq("t3_gnt_again0", 32'(gnt), 0);
        check_eq("t3_count8b", 32'(count), 8);
        check_eq("t3_no_push_full", 32'(fifo_push && fifo_full), 0);
        @(negedge clk); #1;
        check_eq("t3_ovf", 32'(ovf_err), 0);
        check_eq("t3_push_done", 32'(fifo_push), 0);

        // owner drops while another requester appears
        do_reset();
        for (int i = 0; i < N; i++) set_lane(i, 16'(16'hC000 + i));
        @(negedge clk); req = 4'b0010; #1;
        check_eq("t4_gnt0", 32'(gnt), 2);
        @(negedge clk); #1;
        check_eq("t4_gnt1", 32'(gnt), 2);
        @(negedge clk); req = 4'b1000; #1;
        check_eq("t4_handoff", 32'(gnt), 8);
        check_eq("t4_din1", 32'(fifo_din), 'hC001);
        @(negedge clk); req = '0; #1;
        check_eq("t4_ptr", 32'(dbg_ptr), 2);
        check_eq("t4_din3", 32'(fifo_din), 'hC003);
        check_eq("t4_state", 32'(dbg_state), 32'(OWN));

        // reset in the middle of a burst
        do_reset();
        @(negedge clk); req = 4'hF; #1;
        check_eq("t5_gnt0", 32'(gnt), 1);
        @(negedge clk); #1;
        check_eq("t5_gnt1", 32'(gnt), 1);
        check_eq("t5_count1", 32'(count), 1);
        #2; rst = 1'b0; #1;
        check_eq("t5_rst_gnt", 32'(gnt), 0);
        check_eq("t5_rst_push", 32'(fifo_push), 0);
        check_eq("t5_rst_count", 32'(count), 0);
        @(negedge clk); #1;
        check_eq("t5_rst_ptr", 32'(dbg_ptr), 0);
        @(negedge clk); rst = 1'b1; #1;
        check_eq("t5_first_gnt", 32'(gnt), 1);
        req = '0;

        // error injection
        do_reset();
        @(negedge clk); req = 4'b0001; #1;
        check_eq("t6_gnt", 32'(gnt), 1);
        check_eq("t6_ovf0", 32'(ovf_err), 0);
        @(negedge clk); req = '0; force_full = 1'b1; #1;
        check_eq("t6_push", 32'(fifo_push), 1);
        check_eq("t6_ovf1", 32'(ovf_err), 0);
        @(negedge clk); force_full = 1'b0; fifo_pop = 1'b1; #1;
        check_eq("t6_ovf_set", 32'(ovf_err), 1);
        check_eq("t6_count1", 32'(count), 1);
        @(negedge clk); #1;
        check_eq("t6_count0", 32'(count), 0);
        @(negedge clk); fifo_pop = 1'b0; #1;
        check_eq("t6_count_sat", 32'(count), 0);
        check_eq("t6_ovf_held", 32'(ovf_err), 1);
        repeat (3) @(negedge clk);
        #1;
        check_eq("t6_ovf_sticky", 32'(ovf_err), 1);
        do_reset();
        #1;
        check_eq("t6_ovf_cleared", 32'(ovf_err), 0);
        @(negedge clk); fifo_pop = 1'b1; #1;
        check_eq("t6_ovf_pre_pop", 32'(ovf_err), 0);
        @(negedge clk); fifo_pop = 1'b0; #1;
        check_eq("t6_ovf_pop_empty", 32'(ovf_err), 1);
        check_eq("t6_count_empty", 32'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
